pipe_reg_chain: RTL and testbench

PIPE_REG_CHAIN -- requirements
Module: pipe_reg_chain

---
 rtl/pipe_reg_chain_pkg.sv | 12 +
 rtl/pipe_reg_chain_if.sv | 25 ++
 rtl/pipe_reg_chain_stage.sv | 32 +++
 rtl/pipe_reg_chain.sv | 108 ++++++++++
 tb/tb_pipe_reg_chain.sv | 245 ++++++++++++++++++++++++
 5 files changed

// File: rtl/pipe_reg_chain_pkg.sv
// Shared constants and helpers for the pipe_reg_chain register chain.
package pipe_pkg;

   localparam int unsigned DEFAULT_DATA_W = 32;
   localparam int unsigned DEFAULT_STAGES = 4;

   // Bits needed to count 0..stages valid entries.
   function automatic int unsigned occWidth(input int unsigned stages);
      return $clog2(stages + 1);
   endfunction

endpackage

// File: rtl/pipe_reg_chain_if.sv
// Producer/consumer handshake bundle for pipe_reg_chain; slave is the chain's view.
interface pipe_reg_chain_if
   import pipe_pkg::*;
#(
   parameter int unsigned DATA_W = DEFAULT_DATA_W
) ();

   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              out_valid;
   logic              out_ready;
   logic [DATA_W-1:0] out_data;

   modport master (
      output in_valid, in_data, out_ready,
      input  in_ready, out_valid, out_data
   );

   modport slave (
      input  in_valid, in_data, out_ready,
      output in_ready, out_valid, out_data
   );

endinterface

// File: rtl/pipe_reg_chain_stage.sv
// pipe_stage: one valid/data register with load, flush and hold.
module pipe_stage #(
   parameter int unsigned        DATA_W  = 32,
   parameter logic [DATA_W-1:0]  RST_VAL = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enter,
   input  logic              leave,
   input  logic              flush,
   input  logic [DATA_W-1:0] dIn,
   output logic              validNext,
   output logic              validQ,
   output logic [DATA_W-1:0] dataQ
);

   // Flush wins over everything, including an item arriving this cycle.
   assign validNext = !flush && (enter || (validQ && !leave));

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         validQ <= 1'b0;
         dataQ  <= RST_VAL;
      end else begin
         validQ <= validNext;
         if (enter && !flush) begin
            dataQ <= dIn;
         end
      end
   end

endmodule

// File: rtl/pipe_reg_chain.sv
// Valid/ready register chain with bubble collapse, global stall and per-stage flush.
// Define PIPE_PERF_CNT_EN to add the stall_cnt/bubble_cnt performance counters.
module pipe_reg_chain
   import pipe_pkg::*;
#(
   parameter int unsigned       DATA_W  = DEFAULT_DATA_W,
   parameter int unsigned       STAGES  = DEFAULT_STAGES,
   parameter logic [DATA_W-1:0] RST_VAL = '0
) (
   input  logic                         clk,
   input  logic                         rst,
   pipe_reg_chain_if.slave              bus,
   input  logic                         stall,
   input  logic [STAGES-1:0]            flush,
   output logic [occWidth(STAGES)-1:0]  occupancy
`ifdef PIPE_PERF_CNT_EN
   ,
   output logic [31:0]                  stall_cnt,
   output logic [31:0]                  bubble_cnt
`endif
);

   localparam int unsigned OCC_W = occWidth(STAGES);

   logic [STAGES-1:0] validQ;
   logic [STAGES-1:0] validNext;
   logic [STAGES-1:0] advance;
   logic [STAGES-1:0] enter;
   logic [DATA_W-1:0] dataQ [STAGES];
   logic              inReady;
   logic [OCC_W-1:0]  occNext;

   // Walk from the output back: a stage may move if the one ahead is empty or moving.
   always_comb begin
      logic canMove;
      advance = '0;
      canMove = bus.out_ready && !stall;
      for (int unsigned k = 0; k < STAGES; k++) begin
         advance[STAGES-1-k] = validQ[STAGES-1-k] && canMove;
         canMove = !stall && (!validQ[STAGES-1-k] || advance[STAGES-1-k]);
      end
      inReady = canMove && !rst;
   end

   for (genvar g = 0; g < STAGES; g++) begin : gStage
      logic [DATA_W-1:0] dIn;

      if (g == 0) begin : gHead
         assign dIn      = bus.in_data;
         assign enter[g] = bus.in_valid && inReady;
      end else begin : gBody
         assign dIn      = dataQ[g-1];
         assign enter[g] = advance[g-1];
      end

      pipe_stage #(
         .DATA_W  (DATA_W),
         .RST_VAL (RST_VAL)
      ) uStage (
         .clk       (clk),
         .rst       (rst),
         .enter     (enter[g]),
         .leave     (advance[g]),
         .flush     (flush[g]),
         .dIn       (dIn),
         .validNext (validNext[g]),
         .validQ    (validQ[g]),
         .dataQ     (dataQ[g])
      );
   end

   assign bus.in_ready  = inReady;
   assign bus.out_valid = validQ[STAGES-1] && !stall;
   assign bus.out_data  = dataQ[STAGES-1];

   // Counting next-state valids keeps the registered count aligned with v.
   always_comb begin
      occNext = '0;
      for (int unsigned k = 0; k < STAGES; k++) begin
         occNext = occNext + OCC_W'(validNext[k]);
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         occupancy <= '0;
      end else begin
         occupancy <= occNext;
      end
   end

`ifdef PIPE_PERF_CNT_EN
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (stall) begin
            stall_cnt <= stall_cnt + 32'd1;
         end
         if (bus.out_ready && !bus.out_valid && !stall) begin
            bubble_cnt <= bubble_cnt + 32'd1;
         end
      end
   end
`endif

endmodule

// File: tb/tb_pipe_reg_chain.sv
// Scoreboard bench for pipe_reg_chain (STAGES=4); counter checks when PIPE_PERF_CNT_EN is defined.
module tb_pipe_reg_chain;

   localparam logic [31:0] RV = 32'h0000_5A5A;

   typedef struct {
      logic [31:0] d;
      int          cyc;
   } item_t;

   logic        clk = 1'b0;
   logic        rst;
   logic        stall;
   logic [3:0]  flush;
   logic [2:0]  occupancy;
`ifdef PIPE_PERF_CNT_EN
   logic [31:0] stall_cnt;
   logic [31:0] bubble_cnt;
`endif

   item_t sb[$];
   int    cyc;
   int    total;
   int    bad;
   bit    chkLat;

   always #5 clk = ~clk;

   pipe_reg_chain_if #(.DATA_W(32)) bus ();

   pipe_reg_chain #(
      .DATA_W  (32),
      .STAGES  (4),
      .RST_VAL (RV)
   ) dut (
      .clk       (clk),
      .rst       (rst),
      .bus       (bus),
      .stall     (stall),
      .flush     (flush),
      .occupancy (occupancy)
`ifdef PIPE_PERF_CNT_EN
      ,
      .stall_cnt  (stall_cnt),
      .bubble_cnt (bubble_cnt)
`endif
   );

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   // Sample handshakes mid-cycle, update the scoreboard, then advance one clock.
   task automatic step();
      item_t it;
      #1;
      if (bus.in_valid && bus.in_ready) begin
         sb.push_back('{d: bus.in_data, cyc: cyc});
      end
      if (bus.out_valid && bus.out_ready) begin
         chk("out_expected", 64'(sb.size() != 0), 64'd1);
         if (sb.size() != 0) begin
            it = sb.pop_front();
            chk("out_data", 64'(bus.out_data), 64'(it.d));
            if (chkLat) begin
               chk("latency", 64'(cyc - it.cyc), 64'd4);
            end
         end
      end
      @(posedge clk);
      cyc++;
      #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: observed=timeout expected=finish");
      $fatal(1);
   end

   initial begin
      total = 0;
      bad = 0;
      cyc = 0;
      chkLat = 1'b0;
      rst = 1'b1;
      stall = 1'b0;
      flush = '0;
      bus.in_valid = 1'b1;
      bus.in_data = 32'h1;
      bus.out_ready = 1'b1;

      // Reset state
      #2;
      chk("rst_occ", 64'(occupancy), 64'd0);
      chk("rst_in_ready", 64'(bus.in_ready), 64'd0);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_out_data", 64'(bus.out_data), 64'(RV));
      @(posedge clk);
      @(posedge clk);
      #1;
      rst = 1'b0;

      // Streaming, first transfer right after reset
      chkLat = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 32'(i);
         #1;
         chk("stream_in_ready", 64'(bus.in_ready), 64'd1);
         step();
      end
      bus.in_valid = 1'b0;
      repeat (5) step();
      chk("stream_drained", 64'(sb.size()), 64'd0);
      chk("stream_occ", 64'(occupancy), 64'd0);
      chkLat = 1'b0;

      // Fill with backpressure, then drain back to back
      bus.out_ready = 1'b0;
      for (int i = 0; i < 4; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 32'h10 + 32'(i);
         step();
      end
      bus.in_data = 32'h99;
      #1;
      chk("full_in_ready", 64'(bus.in_ready), 64'd0);
      chk("full_occ", 64'(occupancy), 64'd4);
      bus.in_valid = 1'b0;
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         #1;
         chk("drain_out_valid", 64'(bus.out_valid), 64'd1);
         step();
      end
      #1;
      chk("drain_empty_valid", 64'(bus.out_valid), 64'd0);
      chk("drain_sb", 64'(sb.size()), 64'd0);

      // Stall mid-stream
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 32'h21 + 32'(i);
         step();
      end
      stall = 1'b1;
      bus.in_data = 32'h24;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("stall_in_ready", 64'(bus.in_ready), 64'd0);
         chk("stall_out_valid", 64'(bus.out_valid), 64'd0);
         chk("stall_occ", 64'(occupancy), 64'd3);
         step();
      end
      stall = 1'b0;
      for (int i = 3; i < 6; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 32'h21 + 32'(i);
         step();
      end
      bus.in_valid = 1'b0;
      repeat (6) step();
      chk("stall_sb", 64'(sb.size()), 64'd0);
      chk("stall_occ_end", 64'(occupancy), 64'd0);

      // Flush the two youngest stages
      bus.out_ready = 1'b0;
      bus.in_valid = 1'b1;
      bus.in_data = 32'hD; step();
      bus.in_data = 32'hC; step();
      bus.in_data = 32'hB; step();
      bus.in_data = 32'hA; step();
      bus.in_valid = 1'b0;
      #1;
      chk("preflush_occ", 64'(occupancy), 64'd4);
      flush = 4'b0011;
      step();
      flush = '0;
      void'(sb.pop_back());
      void'(sb.pop_back());
      chk("postflush_occ", 64'(occupancy), 64'd2);
      bus.out_ready = 1'b1;
      repeat (4) step();
      chk("flush_sb", 64'(sb.size()), 64'd0);
      chk("flush_occ_end", 64'(occupancy), 64'd0);

      // Reset with three items in flight
      bus.out_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         bus.in_valid = 1'b1;
         bus.in_data = 32'h31 + 32'(i);
         step();
      end
      bus.in_valid = 1'b0;
      #1;
      chk("prerst_occ", 64'(occupancy), 64'd3);
      rst = 1'b1;
      #1;
      chk("midrst_occ", 64'(occupancy), 64'd0);
      chk("midrst_out_data", 64'(bus.out_data), 64'(RV));
      chk("midrst_out_valid", 64'(bus.out_valid), 64'd0);
      sb.delete();
      @(posedge clk);
      #1;
      rst = 1'b0;
      chkLat = 1'b1;
      bus.out_ready = 1'b1;
      bus.in_valid = 1'b1;
      bus.in_data = 32'h44;
      #1;
      chk("postrst_in_ready", 64'(bus.in_ready), 64'd1);
      step();
      bus.in_valid = 1'b0;
      repeat (5) step();
      chk("postrst_sb", 64'(sb.size()), 64'd0);
      chkLat = 1'b0;

`ifdef PIPE_PERF_CNT_EN
      rst = 1'b1;
      #1;
      @(posedge clk);
      #1;
      rst = 1'b0;
      bus.out_ready = 1'b0;
      stall = 1'b1;
      repeat (5) step();
      stall = 1'b0;
      bus.out_ready = 1'b1;
      repeat (2) step();
      bus.out_ready = 1'b0;
      #1;
      chk("stall_cnt", 64'(stall_cnt), 64'd5);
      chk("bubble_cnt", 64'(bubble_cnt), 64'd2);
`endif

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
